fifo_rd_ctrl: RTL and testbench

- Read-side controller for the dual-clock FIFO (FIFOD=8, DATAD=8), clocked entirely in the read domain.
- Issues `rd` strobes to the FIFO whenever data is available and downstream space exists.
- Captures FIFO read data into a 2-entry output buffer and presents it downstream as a valid/ready stream.
- Provides enable/stop control with orderly draining, plus a popped-word counter for bring-up and debug.

---
 rtl/fifo_rd_ctrl.sv | 118 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the dual-clock FIFO: issues rd strobes, buffers returned words in a
// 2-entry skid buffer and presents them as a valid/ready stream. Optional: FIFO_RD_CTRL_PARITY_EN.
module fifo_rd_ctrl #(
  parameter int DATAD = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk_r,
  input  logic             rst,
  input  logic             en,
  input  logic             empty,
  input  logic [DATAD-1:0] fifo_out,
  output logic             rd,
  output logic [DATAD-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_parity,
  output logic             busy,
  output logic [CNTW-1:0]  rd_count
);

  typedef enum logic [1:0] {IDLE, ACTIVE, STOPPING} state_e;

  state_e           state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  logic             pend_q, pend_d;
  logic             head_q, head_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [DATAD-1:0] buf_q [2];
  logic [DATAD-1:0] buf_d [2];
  logic             pop;
  logic             tail;
  logic [2:0]       credit;

  // Datapath: read credit, skid-buffer bookkeeping and pop counter.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pop    = 1'b0;
    rd     = 1'b0;
    credit = '0;
    tail   = 1'b0;
    occ_d  = occ_q;
    head_d = head_q;
    cnt_d  = cnt_q;
    buf_d  = buf_q;

    pop    = (occ_q != 2'd0) && m_ready;
    // Words already held or in flight, minus the one leaving this cycle, must leave a free slot.
    credit = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
    rd     = !rst && (state_q == ACTIVE) && !empty && (credit < 3'd2);

    tail   = head_q ^ occ_q[0];
    if (pend_q) buf_d[tail] = fifo_out;
    occ_d  = occ_q + {1'b0, pend_q} - {1'b0, pop};
    head_d = head_q ^ pop;
    cnt_d  = cnt_q + CNTW'(pop);
  end

  assign pend_d = rd;

  // Stop decisions look at post-edge occupancy so busy drops right after the final pop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (en) state_d = ACTIVE;
      ACTIVE:   if (!en) state_d = ((occ_d != 2'd0) || pend_d) ? STOPPING : IDLE;
      STOPPING: begin
        if (en)                                  state_d = ACTIVE;
        else if ((occ_d == 2'd0) && !pend_d)     state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_r) begin
    if (rst) begin
      state_q <= IDLE;
      occ_q   <= '0;
      pend_q  <= 1'b0;
      head_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      pend_q  <= pend_d;
      head_q  <= head_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: buffer storage is not reset; every read of it is qualified by occupancy.
  always_ff @(posedge clk_r) begin
    buf_q <= buf_d;
  end

  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = m_valid ? buf_q[head_q] : '0;
  assign busy     = (state_q != IDLE);
  assign rd_count = cnt_q;

`ifdef FIFO_RD_CTRL_PARITY_EN
  logic par_q [2];
  logic par_d [2];

  always_comb begin
    par_d = par_q;
    if (pend_q) par_d[tail] = ^fifo_out;
  end

  always_ff @(posedge clk_r) begin
    par_q <= par_d;
  end

  assign m_parity = m_valid ? par_q[head_q] : 1'b0;
`else
  assign m_parity = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: behavioural FIFO model, pop/rd monitor, one task per scenario.
module tb_fifo_rd_ctrl;

  localparam int DATAD = 8;
  localparam int CNTW  = 4;

  logic             clk_r = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             empty;
  logic [DATAD-1:0] fifo_out = '0;
  logic             rd;
  logic [DATAD-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic             m_parity;
  logic             busy;
  logic [CNTW-1:0]  rd_count;

  int checks = 0;
  int errors = 0;

  fifo_rd_ctrl #(.DATAD(DATAD), .CNTW(CNTW)) dut (
    .clk_r    (clk_r),
    .rst      (rst),
    .en       (en),
    .empty    (empty),
    .fifo_out (fifo_out),
    .rd       (rd),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_parity (m_parity),
    .busy     (busy),
    .rd_count (rd_count)
  );

  always #5 clk_r = ~clk_r;

  // FIFO model: word appears on fifo_out the cycle after rd is sampled; reset empties it.
  logic [7:0] mem [256];
  logic [7:0] wp = 8'd0;
  logic [7:0] rp = 8'd0;
  assign empty = (wp == rp);

  always @(posedge clk_r) begin
    if (rst) rp <= wp;
    else if (rd && (wp != rp)) begin
      fifo_out <= mem[rp];
      rp       <= rp + 8'd1;
    end
  end

  // Monitor: one log entry per cycle, sampled on the falling edge.
  logic [7:0] pop_data [$];
  logic       pop_par  [$];
  int         pop_cyc  [$];
  int         rd_cyc   [$];
  logic       busy_log [$];
  int         cyc = 0;
  int         rd_empty_n = 0;

  always @(negedge clk_r) begin
    busy_log.push_back(busy);
    if (m_valid && m_ready) begin
      pop_data.push_back(m_data);
      pop_par.push_back(m_parity);
      pop_cyc.push_back(cyc);
    end
    if (rd) begin
      rd_cyc.push_back(cyc);
      if (empty) rd_empty_n++;
    end
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic exp_par(input logic [7:0] d);
`ifdef FIFO_RD_CTRL_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  task automatic next();
    @(posedge clk_r);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wp] = d;
    wp = wp + 8'd1;
  endtask

  task automatic do_reset();
    next();
    rst = 1'b1;
    en = 1'b0;
    m_ready = 1'b0;
    next();
    rst = 1'b0;
  endtask

  task automatic wait_pops(input int target, input int budget, input string name);
    int k = 0;
    while (pop_data.size() < target && k < budget) begin
      next();
      k++;
    end
    checks++;
    if (pop_data.size() < target) begin
      errors++;
      $display("FAIL %s_timeout: pops %0d required %0d", name, pop_data.size(), target);
    end
  endtask

  task automatic test_reset();
    push(8'h99);
    next();
    next();
    @(negedge clk_r);
    checks++;
    if (rd !== 1'b0) begin errors++; $display("FAIL reset_rd_during_rst: got %b want 0", rd); end
    next();
    rst = 1'b0;
    @(negedge clk_r);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++;
    if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h want 00", m_data); end
    checks++;
    if (m_parity !== 1'b0) begin errors++; $display("FAIL reset_m_parity: got %b want 0", m_parity); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (rd_count !== 4'd0) begin errors++; $display("FAIL reset_rd_count: got %0d want 0", rd_count); end
    checks++;
    if (rd !== 1'b0) begin errors++; $display("FAIL reset_rd_idle: got %b want 0", rd); end
    do_reset();
  endtask

  task automatic test_stream();
    logic [7:0] exp_d [3] = '{8'hA5, 8'h3C, 8'h7E};
    int rb = rd_cyc.size();
    int pb = pop_data.size();
    next();
    push(8'hA5); push(8'h3C); push(8'h7E);
    m_ready = 1'b1;
    en = 1'b1;
    wait_pops(pb + 3, 20, "stream");
    next();
    next();
    @(negedge clk_r);
    checks++;
    if (rd_cyc.size() - rb != 3) begin errors++; $display("FAIL stream_rd_count: got %0d want 3", rd_cyc.size() - rb); end
    else begin
      checks++;
      if (rd_cyc[rb+2] - rd_cyc[rb] != 2) begin errors++; $display("FAIL stream_rd_consecutive: span %0d want 2", rd_cyc[rb+2] - rd_cyc[rb]); end
    end
    if (pop_data.size() - pb == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pop_data[pb+i] !== exp_d[i]) begin errors++; $display("FAIL stream_data%0d: got %h want %h", i, pop_data[pb+i], exp_d[i]); end
      end
      checks++;
      if (pop_cyc[pb+2] - pop_cyc[pb] != 2) begin errors++; $display("FAIL stream_pop_consecutive: span %0d want 2", pop_cyc[pb+2] - pop_cyc[pb]); end
      // rd sampled at the end of cycle N, fifo_out valid in N+1, captured at its end, shown in N+2.
      if (rd_cyc.size() > rb) begin
        checks++;
        if (pop_cyc[pb] - rd_cyc[rb] != 2) begin errors++; $display("FAIL stream_latency: got %0d want 2", pop_cyc[pb] - rd_cyc[rb]); end
      end
    end else begin
      checks++; errors++;
      $display("FAIL stream_pop_count: got %0d want 3", pop_data.size() - pb);
    end
    checks++;
    if (rd_count !== 4'd3) begin errors++; $display("FAIL stream_rd_count_out: got %0d want 3", rd_count); end
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_final_valid: got %b want 0", m_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int rb = rd_cyc.size();
    int pb = pop_data.size();
    int bad = 0;
    next();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(exp_d[i]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_r);
      if (m_valid && m_data !== 8'h11) bad++;
      next();
    end
    @(negedge clk_r);
    checks++;
    if (rd_cyc.size() - rb != 2) begin errors++; $display("FAIL bp_rd_strobes: got %0d want 2", rd_cyc.size() - rb); end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h11) begin errors++; $display("FAIL bp_head: valid %b data %h want 1 11", m_valid, m_data); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_head_stable: %0d changed cycles want 0", bad); end
    next();
    m_ready = 1'b1;
    wait_pops(pb + 5, 20, "bp");
    if (pop_data.size() - pb >= 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (pop_data[pb+i] !== exp_d[i] || pop_cyc[pb+i] != pop_cyc[pb] + i)
          begin errors++; $display("FAIL bp_drain%0d: got %h at +%0d want %h at +%0d", i, pop_data[pb+i], pop_cyc[pb+i] - pop_cyc[pb], exp_d[i], i); end
      end
    end
    next();
    next();
  endtask

  task automatic test_stop();
    int rb = rd_cyc.size();
    int pb = pop_data.size();
    int last;
    for (int i = 0; i < 6; i++) push(8'h61 + 8'(i));
    for (int k = 0; k < 20; k++) begin
      next();
      #1;
      if (en && rd === 1'b1 && (rd_cyc.size() - rb) >= 2) en = 1'b0;
    end
    @(negedge clk_r);
    checks++;
    if (en !== 1'b0) begin errors++; $display("FAIL stop_no_rd_window: en still %b want 0", en); end
    checks++;
    if (rd_cyc.size() - rb != 3) begin errors++; $display("FAIL stop_rd_strobes: got %0d want 3", rd_cyc.size() - rb); end
    checks++;
    if (pop_data.size() - pb != 3) begin errors++; $display("FAIL stop_pops: got %0d want 3", pop_data.size() - pb); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pop_data[pb+i] !== 8'h61 + 8'(i)) begin errors++; $display("FAIL stop_data%0d: got %h want %h", i, pop_data[pb+i], 8'h61 + 8'(i)); end
      end
      last = pop_cyc[pb+2];
      checks++;
      if (busy_log[last] !== 1'b1 || busy_log[last+1] !== 1'b0)
        begin errors++; $display("FAIL stop_busy_fall: got %b%b want 10", busy_log[last], busy_log[last+1]); end
    end
    checks++;
    if (rd !== 1'b0 || busy !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL stop_idle: rd %b busy %b empty %b want 0 0 0", rd, busy, empty); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    int pb = pop_data.size();
    int bad = 0;
    int k = 0;
    logic tog = 1'b1;
    logic hold_pend = 1'b0;
    logic [7:0] hold_d = '0;
    next();
    for (int i = 1; i <= 8; i++) push(8'(i));
    en = 1'b1;
    while (pop_data.size() < pb + 8 && k < 80) begin
      next();
      m_ready = tog;
      tog = ~tog;
      @(negedge clk_r);
      if (hold_pend && (!m_valid || m_data !== hold_d)) bad++;
      hold_pend = m_valid && !m_ready;
      hold_d = m_data;
      k++;
    end
    m_ready = 1'b1;
    repeat (4) next();
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_hold: %0d dropped/changed cycles want 0", bad); end
    checks++;
    if (pop_data.size() - pb != 8) begin errors++; $display("FAIL b2b_pops: got %0d want 8", pop_data.size() - pb); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (pop_data[pb+i] !== 8'(i + 1)) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, pop_data[pb+i], 8'(i + 1)); end
      end
    end
    checks++;
    if (rd_count !== 4'd8) begin errors++; $display("FAIL b2b_rd_count: got %0d want 8", rd_count); end
  endtask

  task automatic test_reset_mid();
    int pb;
    next();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h11 * 8'(i + 1));
    next();
    next();
    rst = 1'b1;
    @(negedge clk_r);
    checks++;
    if (m_valid !== 1'b1 || rd !== 1'b0) begin errors++; $display("FAIL rmid_setup: valid %b rd %b want 1 0", m_valid, rd); end
    next();
    rst = 1'b0;
    pb = pop_data.size();
    push(8'h71);
    push(8'h72);
    @(negedge clk_r);
    checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00) begin errors++; $display("FAIL rmid_valid: valid %b data %h want 0 00", m_valid, m_data); end
    checks++;
    if (busy !== 1'b0 || rd !== 1'b0) begin errors++; $display("FAIL rmid_busy_rd: busy %b rd %b want 0 0", busy, rd); end
    checks++;
    if (rd_count !== 4'd0) begin errors++; $display("FAIL rmid_rd_count: got %0d want 0", rd_count); end
    next();
    m_ready = 1'b1;
    wait_pops(pb + 2, 20, "rmid");
    repeat (3) next();
    checks++;
    if (pop_data.size() - pb != 2) begin errors++; $display("FAIL rmid_pops: got %0d want 2", pop_data.size() - pb); end
    else begin
      checks++;
      if (pop_data[pb] !== 8'h71 || pop_data[pb+1] !== 8'h72)
        begin errors++; $display("FAIL rmid_data: got %h %h want 71 72", pop_data[pb], pop_data[pb+1]); end
    end
    checks++;
    if (rd_count !== 4'd2) begin errors++; $display("FAIL rmid_rd_count_after: got %0d want 2", rd_count); end
  endtask

  task automatic test_parity_wrap();
    int pb = pop_data.size();
    int bad = 0;
    next();
    push(8'h07);
    push(8'h03);
    wait_pops(pb + 2, 20, "parity");
    next();
    @(negedge clk_r);
    if (pop_data.size() - pb == 2) begin
      checks++;
      if (pop_par[pb] !== exp_par(8'h07)) begin errors++; $display("FAIL parity_07: got %b want %b", pop_par[pb], exp_par(8'h07)); end
      checks++;
      if (pop_par[pb+1] !== exp_par(8'h03)) begin errors++; $display("FAIL parity_03: got %b want %b", pop_par[pb+1], exp_par(8'h03)); end
    end
    checks++;
    if (m_valid !== 1'b0 || m_parity !== 1'b0) begin errors++; $display("FAIL parity_idle: valid %b parity %b want 0 0", m_valid, m_parity); end
    do_reset();
    pb = pop_data.size();
    for (int i = 0; i < 17; i++) push(8'h80 + 8'(i * 3));
    en = 1'b1;
    m_ready = 1'b1;
    wait_pops(pb + 17, 80, "wrap");
    repeat (3) next();
    checks++;
    if (rd_count !== 4'd1) begin errors++; $display("FAIL wrap_rd_count: got %0d want 1", rd_count); end
    checks++;
    if (pop_data.size() - pb != 17) begin errors++; $display("FAIL wrap_pops: got %0d want 17", pop_data.size() - pb); end
    else begin
      for (int i = 0; i < 17; i++)
        if (pop_data[pb+i] !== 8'h80 + 8'(i * 3) || pop_par[pb+i] !== exp_par(8'h80 + 8'(i * 3))) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL wrap_data_parity: %0d bad words want 0", bad); end
    end
  endtask

  task automatic test_rd_never_empty();
    checks++;
    if (rd_empty_n != 0) begin errors++; $display("FAIL rd_while_empty: got %0d cycles want 0", rd_empty_n); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    test_parity_wrap();
    test_rd_never_empty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
